// File: rtl/sram_arb2.sv
// rtl/sram_arb2.sv - two-port round-robin arbiter and sequencer for a single-port 32-bit SRAM macro
// Partial byte-enable writes become a read then a full-word merged write in the following MERGE cycle.
module sram_arb2 #(
   parameter int AW = 13
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          p0_req,
   input  logic          p0_we,
   input  logic [AW-1:0] p0_addr,
   input  logic [31:0]   p0_wdata,
   input  logic [3:0]    p0_be,
   input  logic          p1_req,
   input  logic          p1_we,
   input  logic [AW-1:0] p1_addr,
   input  logic [31:0]   p1_wdata,
   input  logic [3:0]    p1_be,
   output logic          p0_gnt,
   output logic          p1_gnt,
   output logic          p0_rvalid,
   output logic          p1_rvalid,
   output logic [31:0]   p0_rdata,
   output logic [31:0]   p1_rdata,
   output logic          sram_cen,
   output logic [3:0]    sram_wen,
   output logic [14:0]   sram_a,
   output logic [31:0]   sram_d,
   input  logic [31:0]   sram_q
);

   typedef enum logic {IDLE, MERGE} state_t;

   state_t        state, state_nx;
   logic          last;
   logic [AW-1:0] lat_addr;
   logic [31:0]   lat_wdata;
   logic [3:0]    lat_be;
   logic          latch_en;

   logic          pick0, pick1;
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [31:0]   sel_wdata;
   logic [3:0]    sel_be;
   logic [31:0]   merged;

   // last = 1 means P1 was granted most recently, so P0 wins the next tie
   assign pick0 = (state == IDLE) && p0_req && (!p1_req || last);
   assign pick1 = (state == IDLE) && p1_req && !pick0;

   assign sel_we    = pick1 ? p1_we    : p0_we;
   assign sel_addr  = pick1 ? p1_addr  : p0_addr;
   assign sel_wdata = pick1 ? p1_wdata : p0_wdata;
   assign sel_be    = pick1 ? p1_be    : p0_be;

   assign p0_gnt   = pick0;
   assign p1_gnt   = pick1;
   assign p0_rdata = sram_q;
   assign p1_rdata = sram_q;

   always_comb begin
      merged = sram_q;
      for (int i = 0; i < 4; i++) begin
         if (lat_be[i]) merged[8*i +: 8] = lat_wdata[8*i +: 8];
      end
   end

   always_comb begin
      state_nx = state;
      latch_en = 1'b0;
      sram_cen = 1'b0;
      sram_wen = 4'h0;
      sram_a   = '0;
      sram_d   = '0;
      case (state)
         IDLE: begin
            if (pick0 || pick1) begin
               sram_a = {{(15-AW){1'b0}}, sel_addr};
               sram_d = sel_wdata;
               if (!sel_we) begin
                  sram_cen = 1'b1;
               end else if (sel_be == 4'hF) begin
                  sram_cen = 1'b1;
                  sram_wen = 4'hF;
               end else if (sel_be != 4'h0) begin
                  // read phase of the read-modify-write
                  sram_cen = 1'b1;
                  latch_en = 1'b1;
                  state_nx = MERGE;
               end
            end
         end
         MERGE: begin
            sram_cen = 1'b1;
            sram_wen = 4'hF;
            sram_a   = {{(15-AW){1'b0}}, lat_addr};
            sram_d   = merged;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         last      <= 1'b1;
         p0_rvalid <= 1'b0;
         p1_rvalid <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_be    <= '0;
      end else begin
         state     <= state_nx;
         p0_rvalid <= pick0 && !p0_we;
         p1_rvalid <= pick1 && !p1_we;
         if (pick0)      last <= 1'b0;
         else if (pick1) last <= 1'b1;
         if (latch_en) begin
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
            lat_be    <= sel_be;
         end
      end
   end

endmodule

// File: tb/tb_sram_arb2.sv
// tb/tb_sram_arb2.sv - randomized scoreboard bench for sram_arb2 with a behavioural SRAM and reference model
// The model tracks memory as a word array and arbitration as a "last winner" flag.
module tb_sram_arb2;
   localparam int AW = 13;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          p0_req = 1'b0, p1_req = 1'b0;
   logic          p0_we = 1'b0, p1_we = 1'b0;
   logic [AW-1:0] p0_addr = '0, p1_addr = '0;
   logic [31:0]   p0_wdata = '0, p1_wdata = '0;
   logic [3:0]    p0_be = '0, p1_be = '0;
   logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
   logic [31:0]   p0_rdata, p1_rdata;
   logic          sram_cen;
   logic [3:0]    sram_wen;
   logic [14:0]   sram_a;
   logic [31:0]   sram_d;
   logic [31:0]   sram_q;

   sram_arb2 #(.AW(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_be(p0_be),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_be(p1_be),
      .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
      .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
      .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // behavioural SRAM macro: one-cycle read latency, full-word writes
   logic [31:0] mem [0:8191];
   logic [31:0] ref_mem [0:8191];
   logic [31:0] q_reg = '0;
   assign sram_q = q_reg;
   always @(posedge clk) begin
      if (sram_cen) begin
         if (sram_wen == 4'hF) mem[sram_a[12:0]] <= sram_d;
         else q_reg <= mem[sram_a[12:0]];
      end
   end

   typedef struct {
      int          when;
      logic [31:0] data;
   } exp_t;
   exp_t expq0[$];
   exp_t expq1[$];

   // reference model
   logic          m_busy = 1'b0, m_last = 1'b1;
   logic [AW-1:0] pend_addr;
   logic [31:0]   pend_data;
   logic          gr0 = 1'b0, gr1 = 1'b0;
   logic          e0, e1, ecen, w;
   logic [3:0]    ewen, be;
   logic [AW-1:0] a;
   logic [31:0]   wd, mask;
   logic [14:0]   ea;
   logic [31:0]   ed;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_busy = 1'b0;
         m_last = 1'b1;
         gr0 = 1'b0;
         gr1 = 1'b0;
         chk("rst_cen", 32'(sram_cen), 32'd0);
         chk("rst_wen", 32'(sram_wen), 32'd0);
      end else begin
         e0 = p0_req && !m_busy && (!p1_req || m_last);
         e1 = p1_req && !m_busy && !e0;
         chk("p0_gnt", 32'(p0_gnt), 32'(e0));
         chk("p1_gnt", 32'(p1_gnt), 32'(e1));
         ecen = 1'b0; ewen = 4'h0; ea = '0; ed = '0;
         if (m_busy) begin
            ecen = 1'b1; ewen = 4'hF; ea = 15'(pend_addr); ed = pend_data;
            ref_mem[pend_addr] = pend_data;
            m_busy = 1'b0;
         end else if (e0 || e1) begin
            w  = e1 ? p1_we    : p0_we;
            a  = e1 ? p1_addr  : p0_addr;
            wd = e1 ? p1_wdata : p0_wdata;
            be = e1 ? p1_be    : p0_be;
            m_last = e1;
            ea = 15'(a);
            if (!w) begin
               ecen = 1'b1;
               if (e1) expq1.push_back('{cyc + 1, ref_mem[a]});
               else    expq0.push_back('{cyc + 1, ref_mem[a]});
            end else if (be == 4'hF) begin
               ecen = 1'b1; ewen = 4'hF; ed = wd;
               ref_mem[a] = wd;
            end else if (be != 4'h0) begin
               ecen = 1'b1;
               mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
               pend_addr = a;
               pend_data = (wd & mask) | (ref_mem[a] & ~mask);
               m_busy = 1'b1;
            end
         end
         chk("sram_cen", 32'(sram_cen), 32'(ecen));
         chk("sram_wen", 32'(sram_wen), 32'(ewen));
         if (ecen) chk("sram_a", 32'(sram_a), 32'(ea));
         if (ecen && ewen == 4'hF) chk("sram_d", sram_d, ed);
         gr0 = e0;
         gr1 = e1;
      end
   end

   // monitor: read data must land on the right port exactly one cycle after its grant
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_p0_rvalid", 32'(p0_rvalid), 32'd0);
         chk("rst_p1_rvalid", 32'(p1_rvalid), 32'd0);
         expq0.delete();
         expq1.delete();
      end else begin
         if (expq0.size() > 0 && expq0[0].when == cyc) begin
            chk("p0_rvalid", 32'(p0_rvalid), 32'd1);
            chk("p0_rdata", p0_rdata, expq0[0].data);
            void'(expq0.pop_front());
         end else if (p0_rvalid) begin
            chk("p0_rvalid_spurious", 32'(p0_rvalid), 32'd0);
         end
         if (expq1.size() > 0 && expq1[0].when == cyc) begin
            chk("p1_rvalid", 32'(p1_rvalid), 32'd1);
            chk("p1_rdata", p1_rdata, expq1[0].data);
            void'(expq1.pop_front());
         end else if (p1_rvalid) begin
            chk("p1_rvalid_spurious", 32'(p1_rvalid), 32'd0);
         end
      end
   end

   function automatic logic [3:0] rnd_be();
      case ($urandom_range(0, 3))
         0:       return 4'hF;
         1:       return 4'h0;
         default: return 4'($urandom_range(1, 14));
      endcase
   endfunction

   logic run = 1'b1;

   task automatic drive();
      if (p0_req && gr0) p0_req = 1'b0;
      if (p1_req && gr1) p1_req = 1'b0;
      if (run && !p0_req && $urandom_range(0, 9) < 8) begin
         p0_req = 1'b1; p0_we = 1'($urandom_range(0, 1));
         p0_addr = AW'($urandom_range(0, 15)); p0_wdata = $urandom; p0_be = rnd_be();
      end
      if (run && !p1_req && $urandom_range(0, 9) < 8) begin
         p1_req = 1'b1; p1_we = 1'($urandom_range(0, 1));
         p1_addr = AW'($urandom_range(0, 15)); p1_wdata = $urandom; p1_be = rnd_be();
      end
   endtask

   logic [31:0] old_word;

   initial begin
      for (int i = 0; i < 8192; i++) begin
         mem[i] = 32'(i) * 32'h9E3779B9;
         ref_mem[i] = 32'(i) * 32'h9E3779B9;
      end
      repeat (2) @(posedge clk);
      #1;
      chk("reset_p0_gnt", 32'(p0_gnt), 32'd0);
      chk("reset_sram_cen", 32'(sram_cen), 32'd0);
      rst_n = 1'b1;

      for (int n = 0; n < 3000; n++) begin
         @(posedge clk); #1;
         drive();
      end
      run = 1'b0;
      for (int n = 0; n < 8; n++) begin
         @(posedge clk); #1;
         drive();
      end
      chk("drained_p0_req", 32'(p0_req), 32'd0);
      chk("drained_p1_req", 32'(p1_req), 32'd0);
      chk("drained_queues", 32'(expq0.size() + expq1.size()), 32'd0);

      // partial write, then reset during its MERGE cycle
      old_word = ref_mem[7];
      p0_req = 1'b1; p0_we = 1'b1; p0_addr = 13'd7; p0_wdata = 32'hAABBCCDD; p0_be = 4'b0101;
      @(posedge clk); #1;
      p0_req = 1'b0;
      chk("merge_cen", 32'(sram_cen), 32'd1);
      chk("merge_wen", 32'(sram_wen), 32'hF);
      rst_n = 1'b0;
      #1;
      chk("rst_in_merge_cen", 32'(sram_cen), 32'd0);
      chk("rst_in_merge_wen", 32'(sram_wen), 32'd0);
      chk("rst_in_merge_rvalid", 32'(p0_rvalid | p1_rvalid), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("word_kept_after_reset", mem[7], old_word);

      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 13'd1;
      p1_req = 1'b1; p1_we = 1'b0; p1_addr = 13'd2;
      #1;
      chk("first_tie_p0_gnt", 32'(p0_gnt), 32'd1);
      chk("first_tie_p1_gnt", 32'(p1_gnt), 32'd0);
      for (int n = 0; n < 6; n++) begin
         @(posedge clk); #1;
         drive();
      end
      chk("final_queues", 32'(expq0.size() + expq1.size()), 32'd0);
      for (int i = 0; i < 16; i++) chk("final_mem", mem[i], ref_mem[i]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_arb2.md
# sram_arb2

Two-port arbiter and sequencer for the single-port 32-bit SRAM macro. It shares the macro between a CPU-side port (P0) and a DMA-side port (P1) with round-robin arbitration and one-cycle read latency. The macro's write path always commits the full 32-bit D word, so this block turns partial byte-enable writes into a read-modify-write (RMW) sequence. It sits between the bus slave adapters and the SRAM macro instance.

## Interface
- `AW`, 13: word-address width; `DEPTH = 2**AW` words.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `p0_req`, `p1_req` in 1: access request, held until granted.
- `p0_we`, `p1_we` in 1: 1 = write, 0 = read.
- `p0_addr`, `p1_addr` in AW: word address.
- `p0_wdata`, `p1_wdata` in 32: write data.
- `p0_be`, `p1_be` in 4: byte enables; bit i covers bits [8i+7:8i]. Ignored for reads.
- `p0_gnt`, `p1_gnt` out 1: request accepted this cycle. Combinational.
- `p0_rvalid`, `p1_rvalid` out 1: read data valid. Registered.
- `p0_rdata`, `p1_rdata` out 32: read data, both driven from `sram_q`.
- `sram_cen` out 1: macro enable, active-high.
- `sram_wen` out 4: macro write enables; only 4'h0 or 4'hF are driven.
- `sram_a` out 15: macro address, `{(15-AW)'b0, addr}`.
- `sram_d` out 32: macro write data.
- `sram_q` in 32: macro read data, valid the cycle after a read-enabled edge.

## Operation
- States:
  - IDLE: may accept a request.
  - MERGE: second cycle of an RMW.
- In IDLE, the arbiter picks one requester:
  - Only one port requesting: that port wins.
  - Both requesting: the port not equal to `last` wins.
  - `last` updates to the granted port on every grant. Reset value is P1, so P0 wins the first tie.
- The granted port's `gnt`=1 in cycle T. Its request drives the macro combinationally in T, sampled at the T/T+1 edge.
- Read: `sram_cen`=1, `sram_wen`=0. In T+1 the granted port's `rvalid`=1 and its `rdata`=`sram_q`. The other port's `rvalid`=0.
- Full write (`be`=4'hF): `sram_cen`=1, `sram_wen`=4'hF, `sram_d`=`wdata`. Single cycle; stays in IDLE.
- Write with `be`=4'h0: granted, no macro access (`sram_cen`=0), stays in IDLE.
- Partial write (`be` not 0 and not F):
  - T: macro read of `addr`; latch `addr`, `wdata`, `be`; go to MERGE.
  - T+1 (MERGE): `sram_cen`=1, `sram_wen`=4'hF, `sram_d` byte i = `be[i]` ? `wdata` byte i : `sram_q` byte i. Both `gnt`=0. Return to IDLE.
  - No `rvalid` is produced for writes.
- Back-to-back accepts every cycle for reads and full writes. An RMW occupies exactly 2 cycles.
- Ordering: accesses hit the macro in grant order. A read granted after a write (including after an RMW) returns the new data.
- Idle cycles (no grant, not MERGE): `sram_cen`=0, `sram_wen`=0, `sram_a`/`sram_d` don't-care.

## Timing
- Reset values: `gnt`=0, `rvalid`=0, `sram_cen`=0, `sram_wen`=0, state=IDLE, `last`=P1. `rdata` follows `sram_q`.
- `gnt` is combinational from `req`, state and `last`; there is no req-to-gnt register stage.
- Read latency: grant in cycle T, data in cycle T+1.
- Maximum wait with both ports requesting continuously: one access (up to 2 cycles) by the other port.
- `rst_n` low during MERGE: the RMW write is dropped (`sram_cen`=0 immediately) and memory keeps its old word. A pending `rvalid` is cleared.
- A request arriving during MERGE is held off and is arbitrated in the next IDLE cycle.

## Test plan
- Reset, then P0 writes addr 0x010, `be`=F, data 0xDEADBEEF; P0 reads 0x010 -> `p0_gnt` at T, `p0_rvalid`=1 at T+1 with 0xDEADBEEF, `p1_rvalid`=0.
- Partial write: word 0x020 preloaded with 0x11223344; P1 writes `be`=4'b0101, data 0xAABBCCDD -> `sram_cen`=1 in 2 consecutive cycles, `sram_wen`=0 then F, `sram_d`=0x11BB33DD; a read of 0x020 then returns 0x11BB33DD.
- Both ports request reads every cycle for 8 cycles -> grants alternate P0,P1,P0,…; each `rvalid` lands on the correct port one cycle after its grant.
- P0 partial write and P1 read requested together with `last`=P1 -> P0 granted and MERGE runs; P1 is granted in the cycle after MERGE and its `rvalid` follows one cycle later.
- P0 write with `be`=0 -> `p0_gnt`=1, `sram_cen`=0, memory unchanged.
- Assert `rst_n` low during MERGE -> target word unchanged, all outputs at reset values, and a first tie after reset grants P0.
